// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared constants and helpers for the push-button conditioning stage.
//   CLK_HZ                  : nominal system clock, used to derive defaults
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms worth of clock cycles at CLK_HZ
//   KEY_IDLE()              : inactive (released) level of one key bit
// ---------------------------------------------------------------------------
package key_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  // 10 ms of stability at 50 MHz before a new key level is believed.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;

  // Active-low keys idle high; active-high keys idle low.
  function automatic logic KEY_IDLE(input bit activeLow);
    return logic'(activeLow);
  endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// ---------------------------------------------------------------------------
// key_debounce_bit
// One key channel: 2-flop synchroniser, stability counter, accepted-level
// register and one-cycle press/release pulse generation.
// Ports:
//   clk_i        : system clock, rising edge
//   reset_n_i    : synchronous active-low reset
//   key_raw_i    : raw asynchronous key pin
//   key_o        : debounced level, same polarity as key_raw_i
//   press_o      : 1-cycle pulse when the accepted level becomes pressed
//   release_o    : 1-cycle pulse when the accepted level becomes released
//   stable_d_o   : next-state accepted level, lets the parent register
//                  aggregate flags on the same edge as key_o
// ---------------------------------------------------------------------------
module key_debounce_bit
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic key_raw_i,
  output logic key_o,
  output logic press_o,
  output logic release_o,
  output logic stable_d_o
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            IDLE    = KEY_IDLE(ACTIVE_LOW);
  localparam logic            PRESSED = ~IDLE;

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;

  // Debounce decision for this edge. Any sample that agrees with the
  // accepted level throws away the partial count, so only an unbroken run
  // of DEBOUNCE_CYCLES differing samples is ever accepted. The counter
  // saturates at CNT_MAX by construction because reaching it forces either
  // acceptance or a clear.
  always_comb begin
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d  = sync2_q;
      cnt_d     = '0;
      press_d   = (sync2_q == PRESSED);
      release_d = (sync2_q != PRESSED);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser and debounce state. Reset parks everything at the idle
  // level, which also discards any transition that was mid-count, and
  // clears the pulse registers so neither reset entry nor exit emits one.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync1_q   <= IDLE;
      sync2_q   <= IDLE;
      stable_q  <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_raw_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_o      = stable_q;
  assign press_o    = press_q;
  assign release_o  = release_q;
  assign stable_d_o = reset_n_i ? stable_d : IDLE;

endmodule

// File: rtl/key_debounce_sync.sv
// ---------------------------------------------------------------------------
// key_debounce_sync
// Conditions raw board push-buttons for the PIO in_port: each key is
// synchronised and debounced independently, and one-cycle press/release
// pulses are produced for local logic. Output polarity follows the raw keys.
// Ports:
//   clk           : system clock, rising edge
//   reset_n       : synchronous active-low reset
//   key_raw       : raw asynchronous key pins
//   key_out       : debounced levels, drives PIO in_port
//   press_pulse   : per-key 1-cycle pulse on accepted press
//   release_pulse : per-key 1-cycle pulse on accepted release
//   any_pressed   : registered OR of debounced pressed state
// ---------------------------------------------------------------------------
module key_debounce_sync
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic                any_pressed
);

  localparam logic [NUM_KEYS-1:0] IDLE_VEC = {NUM_KEYS{KEY_IDLE(ACTIVE_LOW)}};

  logic [NUM_KEYS-1:0] stable_d;
  logic                any_pressed_d;
  logic                any_pressed_q;

  // One fully independent channel per key.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_bit (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .key_raw_i (key_raw[k]),
      .key_o     (key_out[k]),
      .press_o   (press_pulse[k]),
      .release_o (release_pulse[k]),
      .stable_d_o(stable_d[k])
    );
  end

  // A key counts as pressed whenever its accepted level differs from idle;
  // using next-state levels keeps this flag aligned with key_out.
  assign any_pressed_d = |(stable_d ^ IDLE_VEC);

  // Registered aggregate flag, cleared by reset like every other output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      any_pressed_q <= 1'b0;
    end else begin
      any_pressed_q <= any_pressed_d;
    end
  end

  assign any_pressed = any_pressed_q;

endmodule

// File: tb/tb_key_debounce_sync.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_sync
// Two instances share one stimulus stream: dut4 with a 4-cycle debounce
// window and dut1 with the minimum 1-cycle window. A window-based model
// predicts every output each cycle; literal checks pin key moments.
// ---------------------------------------------------------------------------
module tb_key_debounce_sync;

  logic       clk = 1'b0;
  logic       resetN;
  logic [3:0] keyRaw;

  logic [3:0] keyOut4, press4, release4;
  logic       any4;
  logic [3:0] keyOut1, press1, release1;
  logic       any1;

  int  nChecks = 0;
  int  nFail   = 0;
  bit  checkEn = 1'b0;

  // Clock generation, 10 time-unit period.
  always #5 clk = ~clk;

  key_debounce_sync #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut4 (
    .clk          (clk),
    .reset_n      (resetN),
    .key_raw      (keyRaw),
    .key_out      (keyOut4),
    .press_pulse  (press4),
    .release_pulse(release4),
    .any_pressed  (any4)
  );

  key_debounce_sync #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b1)) dut1 (
    .clk          (clk),
    .reset_n      (resetN),
    .key_raw      (keyRaw),
    .key_out      (keyOut1),
    .press_pulse  (press1),
    .release_pulse(release1),
    .any_pressed  (any1)
  );

  // Model state: index 0 mirrors dut4, index 1 mirrors dut1.
  // hist[m][j] holds the raw sample taken j edges ago (j = 0 is this edge).
  logic [3:0] hist   [2][8];
  logic [3:0] mKey   [2];
  logic [3:0] mPress [2];
  logic [3:0] mRel   [2];
  logic       mAny   [2];

  // Behavioural model: a key's level flips when the samples seen through the
  // two-edge synchroniser delay have all disagreed with the accepted level
  // for the last D edges. Reset makes the whole history look idle.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int d;
      bit flip;
      d = (m == 0) ? 4 : 1;
      if (!resetN) begin
        for (int j = 0; j < 8; j++) hist[m][j] = 4'hF;
        mKey[m]   = 4'hF;
        mPress[m] = 4'h0;
        mRel[m]   = 4'h0;
        mAny[m]   = 1'b0;
      end else begin
        for (int j = 7; j > 0; j--) hist[m][j] = hist[m][j-1];
        hist[m][0] = keyRaw;
        mPress[m]  = 4'h0;
        mRel[m]    = 4'h0;
        for (int i = 0; i < 4; i++) begin
          flip = 1'b1;
          for (int j = 2; j <= d + 1; j++) begin
            if (hist[m][j][i] == mKey[m][i]) flip = 1'b0;
          end
          if (flip) begin
            mKey[m][i] = ~mKey[m][i];
            if (mKey[m][i] == 1'b0) mPress[m][i] = 1'b1;
            else                    mRel[m][i]   = 1'b1;
          end
        end
        mAny[m] = (mKey[m] != 4'hF);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Drive inputs at the falling edge, then run the requested number of
  // rising edges, returning on a falling edge so outputs are settled.
  task automatic applyStimulus(input logic [3:0] raw, input logic rstn, input int cycles);
    keyRaw = raw;
    resetN = rstn;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model dut4 key_out",       keyOut4,        mKey[0]);
      checkOutput("model dut4 press_pulse",   press4,         mPress[0]);
      checkOutput("model dut4 release_pulse", release4,       mRel[0]);
      checkOutput("model dut4 any_pressed",   {3'b0, any4},   {3'b0, mAny[0]});
      checkOutput("model dut1 key_out",       keyOut1,        mKey[1]);
      checkOutput("model dut1 press_pulse",   press1,         mPress[1]);
      checkOutput("model dut1 release_pulse", release1,       mRel[1]);
      checkOutput("model dut1 any_pressed",   {3'b0, any1},   {3'b0, mAny[1]});
    end
  end

  initial begin
    // Reset held for three edges with keys reading pressed.
    applyStimulus(4'h0, 1'b0, 1);
    checkEn = 1'b1;
    applyStimulus(4'h0, 1'b0, 2);
    checkOutput("reset key_out",     keyOut4,      4'hF);
    checkOutput("reset press",       press4,       4'h0);
    checkOutput("reset release",     release4,     4'h0);
    checkOutput("reset any_pressed", {3'b0, any4}, 4'h0);
    checkOutput("reset dut1 key_out", keyOut1,     4'hF);

    // Reset release with keys idle: nothing should ever fire.
    applyStimulus(4'hF, 1'b1, 10);
    checkOutput("idle key_out", keyOut4, 4'hF);

    // Clean press of key 0, accepted on edge 6.
    applyStimulus(4'hE, 1'b1, 5);
    checkOutput("press edge5 key_out", keyOut4, 4'hF);
    applyStimulus(4'hE, 1'b1, 1);
    checkOutput("press edge6 key_out", keyOut4,      4'hE);
    checkOutput("press edge6 pulse",   press4,       4'h1);
    checkOutput("press edge6 any",     {3'b0, any4}, 4'h1);
    applyStimulus(4'hE, 1'b1, 1);
    checkOutput("press edge7 pulse",   press4,       4'h0);
    applyStimulus(4'hE, 1'b1, 3);

    // Bounce on key 1: 3 low, 1 high, 3 low, then high again.
    applyStimulus(4'hC, 1'b1, 3);
    applyStimulus(4'hE, 1'b1, 1);
    applyStimulus(4'hC, 1'b1, 3);
    applyStimulus(4'hE, 1'b1, 3);
    checkOutput("bounce key_out", keyOut4, 4'hE);
    applyStimulus(4'hC, 1'b1, 5);
    checkOutput("bounce hold edge5 key_out", keyOut4, 4'hE);
    applyStimulus(4'hC, 1'b1, 1);
    checkOutput("bounce hold edge6 key_out", keyOut4, 4'hC);
    checkOutput("bounce hold edge6 press",   press4,  4'h2);
    applyStimulus(4'hC, 1'b1, 4);

    // All keys pressed, then all released together.
    applyStimulus(4'h0, 1'b1, 8);
    checkOutput("all pressed key_out", keyOut4, 4'h0);
    applyStimulus(4'hF, 1'b1, 5);
    checkOutput("release edge5 key_out", keyOut4, 4'h0);
    applyStimulus(4'hF, 1'b1, 1);
    checkOutput("release edge6 key_out", keyOut4,      4'hF);
    checkOutput("release edge6 pulse",   release4,     4'hF);
    checkOutput("release edge6 any",     {3'b0, any4}, 4'h0);
    applyStimulus(4'hF, 1'b1, 1);
    checkOutput("release edge7 pulse",   release4,     4'h0);
    applyStimulus(4'hF, 1'b1, 3);

    // Reset on edge 4 while key 2 is counting.
    applyStimulus(4'hB, 1'b1, 3);
    applyStimulus(4'hB, 1'b0, 1);
    applyStimulus(4'hB, 1'b1, 2);
    checkOutput("midreset edge6 press",   press4,  4'h0);
    checkOutput("midreset edge6 key_out", keyOut4, 4'hF);
    applyStimulus(4'hB, 1'b1, 3);
    checkOutput("midreset restart edge5 key_out", keyOut4, 4'hF);
    applyStimulus(4'hB, 1'b1, 1);
    checkOutput("midreset restart edge6 key_out", keyOut4, 4'hB);
    checkOutput("midreset restart edge6 press",   press4,  4'h4);

    // One-cycle glitch on key 3: only the 1-cycle window instance reacts.
    applyStimulus(4'hF, 1'b1, 8);
    applyStimulus(4'h7, 1'b1, 1);
    applyStimulus(4'hF, 1'b1, 1);
    checkOutput("glitch edge2 dut1 key_out", keyOut1,  4'hF);
    applyStimulus(4'hF, 1'b1, 1);
    checkOutput("glitch edge3 dut1 key_out", keyOut1,  4'h7);
    checkOutput("glitch edge3 dut1 press",   press1,   4'h8);
    checkOutput("glitch edge3 dut1 release", release1, 4'h0);
    applyStimulus(4'hF, 1'b1, 1);
    checkOutput("glitch edge4 dut1 key_out", keyOut1,  4'hF);
    checkOutput("glitch edge4 dut1 press",   press1,   4'h0);
    checkOutput("glitch edge4 dut1 release", release1, 4'h8);
    checkOutput("glitch edge4 dut4 key_out", keyOut4,  4'hF);
    applyStimulus(4'hF, 1'b1, 6);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
